// File: rtl/mul_flow_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_flow_arbiter_if
// Description : Requester, multiplier and result signals of the shared
//               multiplier arbiter. slave = arbiter, master = surroundings
//               (requesters, multiplier P output, result sinks).
// Revision    : 1.0  initial release
// ============================================================================
interface mul_flow_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              hold;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_p;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_p;
    logic [3:0]        inflight;
    logic              idle;

    modport master (
        output req_valid, req_a, req_b, hold, mul_p,
        input  req_ready, mul_a, mul_b, res_valid, res_id, res_p, inflight, idle
    );

    modport slave (
        input  req_valid, req_a, req_b, hold, mul_p,
        output req_ready, mul_a, mul_b, res_valid, res_id, res_p, inflight, idle
    );
endinterface
`default_nettype wire

// File: rtl/mul_flow_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_flow_arbiter
// Description : Round-robin arbiter sharing one fixed-latency pipelined 8x8
//               multiplier among NREQ requesters. A {valid,id} tag pipeline
//               of depth LATENCY tracks each issued operation so the product
//               returns tagged with its originator.
//               Optional macro MUL_FLOW_ARBITER_RESREG_EN registers the result
//               outputs (total latency LATENCY+1).
// Revision    : 1.0  initial release
// ============================================================================
module mul_flow_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LATENCY = 7
) (
    input  wire logic          CP,
    input  wire logic          CLR_,
    mul_flow_arbiter_if.slave  bus
);

    localparam logic [IDW-1:0] c_last_rst = IDW'(NREQ - 1);

    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   w_gidx;
    logic             w_xfer;
    logic             w_ret;
    logic [LATENCY-1:0] r_tag_v;
    logic [IDW-1:0]   r_tag_id [LATENCY];
    logic [3:0]       r_inflight;

    // Round-robin search starting just after the last granted requester
    always_comb begin : p_arb
        logic [IDW-1:0] v_idx;
        logic           v_found;
        v_idx   = '0;
        v_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = IDW'((int'(r_last_grant) + k) % NREQ);
            if (!v_found && bus.req_valid[v_idx]) begin
                v_found = 1'b1;
                w_gidx  = v_idx;
            end
        end
        // No grant while held or in reset; id forced to 0 so idle tags stay clean
        w_xfer = v_found && !bus.hold && CLR_;
        if (!w_xfer) begin
            w_gidx = '0;
        end
    end

    assign bus.req_ready = w_xfer ? (NREQ'(1) << w_gidx) : '0;
    assign bus.mul_a     = w_xfer ? bus.req_a[{w_gidx, 3'b000} +: 8] : 8'h00;
    assign bus.mul_b     = w_xfer ? bus.req_b[{w_gidx, 3'b000} +: 8] : 8'h00;

    // Remember the last granted requester so rotation resumes after it
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_last_grant <= c_last_rst;
        end else if (w_xfer) begin
            r_last_grant <= w_gidx;
        end
    end

    // Tag pipeline aligned with the multiplier latency; shifts every cycle
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_gidx;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

`ifdef MUL_FLOW_ARBITER_RESREG_EN
    logic           r_res_valid;
    logic [IDW-1:0] r_res_id;
    logic [15:0]    r_res_p;

    // Registered result stage; product zeroed on empty slots to keep it stable
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_p     <= '0;
        end else begin
            r_res_valid <= r_tag_v[LATENCY-1];
            r_res_id    <= r_tag_id[LATENCY-1];
            r_res_p     <= r_tag_v[LATENCY-1] ? bus.mul_p : 16'h0000;
        end
    end

    assign w_ret         = r_res_valid;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_p     = r_res_p;
`else
    assign w_ret         = r_tag_v[LATENCY-1];
    assign bus.res_valid = r_tag_v[LATENCY-1];
    assign bus.res_id    = r_tag_id[LATENCY-1];
    assign bus.res_p     = r_tag_v[LATENCY-1] ? bus.mul_p : 16'h0000;
`endif

    // Operations in flight: +1 on issue, -1 when a result is presented
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            r_inflight <= 4'd0;
        end else begin
            case ({w_xfer, w_ret})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.inflight = r_inflight;
    assign bus.idle     = (r_inflight == 4'd0) && !w_xfer;

endmodule
`default_nettype wire

// File: tb/tb_mul_flow_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_flow_arbiter
// Description : Self-checking bench for mul_flow_arbiter: behavioural
//               round-robin/result-queue model compared every cycle, plus
//               directed scenarios with hand-computed expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_flow_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 7;
`ifdef MUL_FLOW_ARBITER_RESREG_EN
    localparam int EXP_LAT = LAT + 1;
`else
    localparam int EXP_LAT = LAT;
`endif

    logic CP   = 1'b0;
    logic CLR_ = 1'b0;

    always #5 CP = ~CP;

    mul_flow_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul_flow_arbiter #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LAT)) dut (
        .CP   (CP),
        .CLR_ (CLR_),
        .bus  (bus)
    );

    // Attached multiplier: LAT register stages, cleared by the same CLR_
    logic [15:0] r_mpipe [LAT];
    always_ff @(posedge CP or negedge CLR_) begin
        if (!CLR_) begin
            for (int i = 0; i < LAT; i++) r_mpipe[i] <= '0;
        end else begin
            r_mpipe[0] <= {8'h00, bus.mul_a} * {8'h00, bus.mul_b};
            for (int i = 1; i < LAT; i++) r_mpipe[i] <= r_mpipe[i-1];
        end
    end
    assign bus.mul_p = r_mpipe[LAT-1];

    int cyc = 0;
    always @(posedge CP) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Logs of actual DUT grants and results, inspected by directed checks
    int g_idx[$];
    int g_cyc[$];
    int r_id[$];
    int r_p[$];
    int r_cyc[$];

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete();
        r_id.delete();  r_p.delete(); r_cyc.delete();
    endtask

    // Model: round-robin pointer plus queue of pending results with due cycle
    typedef struct {
        int due;
        int id;
        int p;
    } exp_t;

    exp_t q[$];
    int   m_last = NREQ - 1;

    always @(negedge CP) begin : compare
        int   eg;
        int   idx;
        int   ea;
        int   eb;
        logic ex;
        logic ev;
        if (!CLR_) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_res_id",    bus.res_id, 0);
            check("rst_inflight",  bus.inflight, 0);
            check("rst_idle",      bus.idle, 1);
            q.delete();
            m_last = NREQ - 1;
        end else begin
            ex = 1'b0;
            eg = 0;
            if (!bus.hold) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (!ex && bus.req_valid[idx]) begin
                        ex = 1'b1;
                        eg = idx;
                    end
                end
            end
            ea = ex ? int'(bus.req_a[8*eg +: 8]) : 0;
            eb = ex ? int'(bus.req_b[8*eg +: 8]) : 0;
            check("req_ready", bus.req_ready, ex ? (1 << eg) : 0);
            check("mul_a",     bus.mul_a, ea);
            check("mul_b",     bus.mul_b, eb);
            check("inflight",  bus.inflight, q.size());
            check("idle",      bus.idle, (q.size() == 0 && !ex) ? 1 : 0);
            ev = (q.size() > 0) && (q[0].due == cyc);
            check("res_valid", bus.res_valid, ev);
            if (ev) begin
                check("res_id", bus.res_id, q[0].id);
                check("res_p",  bus.res_p,  q[0].p);
                void'(q.pop_front());
            end
            if (ex) begin
                q.push_back('{due: cyc + EXP_LAT, id: eg, p: ea * eb});
                m_last = eg;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (bus.res_valid) begin
                r_id.push_back(int'(bus.res_id));
                r_p.push_back(int'(bus.res_p));
                r_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        bus.req_a[8*i +: 8] = 8'(a);
        bus.req_b[8*i +: 8] = 8'(b);
    endtask

    task automatic pulse_reset();
        CLR_ = 1'b0;
        tick(2);
        CLR_ = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int t0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.hold      = 1'b0;
        tick(2);
        CLR_ = 1'b1;
        tick(1);

        // Single request from requester 2: 12*13
        clear_logs();
        set_req(2, 12, 13);
        bus.req_valid = 4'b0100;
        t0 = cyc;
        tick(1);
        bus.req_valid = '0;
        tick(3);
        check("s1_inflight_mid", bus.inflight, 1);
        tick(EXP_LAT + 3);
        check("s1_count", r_id.size(), 1);
        if (r_id.size() == 1) begin
            check("s1_id",      r_id[0], 2);
            check("s1_p",       r_p[0], 156);
            check("s1_latency", r_cyc[0] - t0, EXP_LAT);
        end
        check("s1_idle",     bus.idle, 1);
        check("s1_inflight", bus.inflight, 0);

        // All four continuously valid after reset: rotation 0,1,2,3,...
        pulse_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 20 + i);
        bus.req_valid = 4'hF;
        tick(12);
        check("s2_inflight_sat", bus.inflight, EXP_LAT);
        bus.req_valid = '0;
        tick(EXP_LAT + 3);
        check("s2_grants", g_idx.size(), 12);
        check("s2_results", r_id.size(), 12);
        if (g_idx.size() >= 8 && r_id.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("s2_grant_order", g_idx[k], k % 4);
                check("s2_res_id",      r_id[k], k % 4);
                check("s2_res_b2b",     r_cyc[k] - r_cyc[0], k);
            end
            check("s2_p0", r_p[0], 200);
            check("s2_p3", r_p[3], 299);
        end

        // Extreme operands
        clear_logs();
        set_req(0, 255, 255);
        bus.req_valid = 4'b0001;
        tick(1);
        set_req(0, 0, 200);
        tick(1);
        bus.req_valid = '0;
        tick(EXP_LAT + 3);
        check("s3_count", r_id.size(), 2);
        if (r_id.size() == 2) begin
            check("s3_p_max",  r_p[0], 65025);
            check("s3_p_zero", r_p[1], 0);
            check("s3_id",     r_id[1], 0);
            check("s3_b2b",    r_cyc[1] - r_cyc[0], 1);
        end

        // hold with requests pending while earlier results drain
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 3 + i, 5 + i);
        bus.req_valid = 4'hF;
        tick(2);
        bus.req_valid = '0;
        tick(4);
        bus.req_valid = 4'hF;
        bus.hold = 1'b1;
        #1;
        check("s4_hold_ready", bus.req_ready, 0);
        check("s4_hold_mul_a", bus.mul_a, 0);
        check("s4_hold_mul_b", bus.mul_b, 0);
        tick(3);
        bus.hold = 1'b0;
        tick(2);
        bus.req_valid = '0;
        tick(EXP_LAT + 3);
        check("s4_grants", g_idx.size(), 4);
        check("s4_results", r_id.size(), 4);
        if (g_idx.size() == 4 && r_id.size() == 4) begin
            check("s4_g0", g_idx[0], 1);
            check("s4_g1", g_idx[1], 2);
            check("s4_g2", g_idx[2], 3);
            check("s4_g3", g_idx[3], 0);
            check("s4_gap", g_cyc[2] - g_cyc[1], 8);
            check("s4_drain_lat", r_cyc[0] - g_cyc[0], EXP_LAT);
            check("s4_p0", r_p[0], 4 * 6);
        end

        // Reset with four operations in flight
        clear_logs();
        bus.req_valid = 4'hF;
        tick(4);
        bus.req_valid = '0;
        check("s5_inflight_pre", bus.inflight, 4);
        pulse_reset();
        clear_logs();
        tick(EXP_LAT + 3);
        check("s5_no_results", r_id.size(), 0);
        check("s5_inflight",   bus.inflight, 0);
        bus.req_valid = 4'hF;
        tick(1);
        bus.req_valid = '0;
        tick(1);
        check("s5_grants", g_idx.size(), 1);
        if (g_idx.size() == 1) begin
            check("s5_first_grant", g_idx[0], 0);
        end
        tick(EXP_LAT + 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_flow_arbiter.md
Name: mul_flow_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one 8x8 pipelined multiplier (fixed latency, no stall, one issue per cycle) between NREQ requesters.
- Issues at most one operand pair per cycle. Carries requester ID and valid through a tag pipeline matched to the multiplier latency.
- Returns each product tagged with its originator.
- Sits between the requesting units and the multiplier instance; drives the multiplier's A/B and reads its P.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ
- LATENCY, 7, clock edges from operands applied on mul_a/mul_b to product valid on mul_p; must equal the attached multiplier's latency

Ports:
- CP  input  1  clock, rising edge
- CLR_  input  1  reset, asynchronous, active-low; also drives the multiplier's CLR_
- req_valid  input  NREQ  per-requester operand valid
- req_a  input  8*NREQ  multiplicand, requester i at bits [8i+7:8i]
- req_b  input  8*NREQ  multiplier, same packing
- req_ready  output  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- hold  input  1  suspend new issues; in-flight operations still drain
- mul_a  output  8  to multiplier A
- mul_b  output  8  to multiplier B
- mul_p  input  16  from multiplier P
- res_valid  output  1  result valid, single-cycle pulse per result
- res_id  output  IDW  originating requester of res_p
- res_p  output  16  product
- inflight  output  4  operations issued but not yet returned, 0..LATENCY
- idle  output  1  high when inflight==0 and no issue this cycle

Behaviour:
- Arbitration:
  - Combinational round-robin over req_valid, searching from (last_grant+1) mod NREQ upward.
  - req_ready is one-hot among valid requesters. It is all-zero when hold=1 or when no request is valid.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- last_grant register:
  - Updates to the granted index on each transfer edge; otherwise holds.
  - Reset value NREQ-1, so requester 0 wins the first contention.
- Issue:
  - mul_a and mul_b are combinational muxes of the granted requester's operands.
  - They are forced to 8'h00 when there is no transfer, which keeps idle cycles deterministic.
- Tag pipeline:
  - LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads {transfer, granted index} each edge. Every stage shifts every cycle with no stall.
- Result:
  - res_valid, res_id come from the last tag stage. res_p = mul_p, qualified by res_valid.
  - res_p is unspecified but stable when res_valid=0.
  - No backpressure on results: sinks must accept in the cycle presented.
- Latency: result appears LATENCY edges after the transfer edge. Throughput is 1 result/cycle sustained.
- inflight counter:
  - +1 on a transfer, -1 when the last tag stage is valid.
  - Both in the same cycle: unchanged.
  - Never exceeds LATENCY and never underflows.
- hold:
  - Sampled combinationally; it blocks the transfer in the same cycle.
  - Deasserting hold resumes arbitration from the stored last_grant.
- Reset values:
  - All tag stages invalid, last_grant=NREQ-1, inflight=0.
  - res_valid=0, res_id=0, req_ready=0 while CLR_ low, idle=1.
- Reset mid-operation: all in-flight operations are discarded, with no result pulses. The multiplier is cleared by the same CLR_.
- Fairness: a requester holding req_valid high is granted within NREQ cycles while hold=0.

Optional Feature:
- Macro MUL_FLOW_ARBITER_RESREG_EN.
- Defined:
  - res_valid, res_id and res_p are registered, adding one cycle; total latency LATENCY+1.
  - Registers reset to 0.
  - inflight decrements when the registered result is presented.
- Undefined: outputs are combinational from the last tag stage and mul_p as above. Total latency LATENCY.

Test Plan:
- Single request: requester 2, a=12, b=13, one-cycle valid -> res_valid exactly LATENCY edges later, res_id=2, res_p=156. inflight 1 during flight, then 0. idle returns to 1.
- All four requesters valid continuously with distinct operands -> grant order 0,1,2,3,0,1,... one per cycle. Back-to-back results with matching ids and products; inflight saturates at 7.
- Max operands: a=255, b=255 from requester 0 -> res_p=65025. Also a=0, b=200 -> res_p=0 with res_valid=1.
- hold asserted for 3 cycles with requests pending -> req_ready=0, mul_a=mul_b=0, no new issues. Existing results still arrive. Rotation continues after last_grant on release.
- CLR_ pulsed low with 4 operations in flight -> no res_valid pulses afterwards, inflight=0, the next grant goes to requester 0.
- With MUL_FLOW_ARBITER_RESREG_EN defined, repeat scenario 1 -> result at LATENCY+1 edges, values identical.
